// File: rtl/boot_pkg.sv
// boot_pkg: shared FSM state codes and constants for the imem UART bootloader
package boot_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_CNT_LO  = 3'd1;
  localparam state_t S_CNT_HI  = 3'd2;
  localparam state_t S_DATA    = 3'd3;
  localparam state_t S_CSUM    = 3'd4;
  localparam state_t S_RELEASE = 3'd5;
  localparam state_t S_HALT    = 3'd6;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: packs little-endian bytes into 32-bit words with a running XOR
// ports: clk/rst, clr (restart frame), en+din (data byte), word/word_valid (one cycle after 4th byte),
//        last_byte (next byte completes a word), csum (XOR of all data bytes so far)
module boot_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte,
  output logic [7:0]  csum
);
  logic [1:0]  idx_q;
  logic [31:0] sr_q;
  logic [7:0]  csum_q;
  logic        vld_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      sr_q   <= '0;
      csum_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= !clr && en && &idx_q;
      if (clr) begin
        idx_q  <= '0;
        sr_q   <= '0;
        csum_q <= '0;
      end else if (en) begin
        sr_q[{idx_q, 3'b000} +: 8] <= din;
        idx_q  <= idx_q + 2'd1;
        csum_q <= csum_q ^ din;
      end
    end
  end
  assign word       = sr_q;
  assign word_valid = vld_q;
  assign last_byte  = &idx_q;
  assign csum       = csum_q;
endmodule

// File: rtl/imem_boot_arbiter.sv
// imem_boot_arbiter: UART frame loader for imem and arbiter of its single address port
// ports: clk/rst, rx_data/rx_valid (UART bytes), cpu_addr/cpu_rdata/cpu_stall/cpu_rst_req (fetch side),
//        mem_addr/mem_rdata/mem_we/mem_wdata (imem side), load_busy/load_done/load_err (status)
module imem_boot_arbiter
  import boot_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [31:0]       cpu_addr,
  output logic [31:0]       cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              cpu_rst_req,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);
  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] ONE = 1;
  state_t            state_q, state_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W:0]   n_q, n_d, widx_q, widx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              done_q, done_d, err_q, err_d;
  logic [31:0]       word;
  logic [7:0]        csum;
  logic              word_valid, last_byte;
  logic              idle, active, sync, timeout, cnt_ok;
  logic [15:0]       cnt;
  logic              unused_addr;
  assign idle    = state_q == S_IDLE;
  assign active  = state_q inside {S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM};
  assign sync    = rx_valid && rx_data == SYNC_BYTE && (idle || state_q == S_HALT);
  // a byte arriving in the expiry cycle takes precedence over the timeout
  assign timeout = active && !rx_valid && gap_q == GW'(TIMEOUT_CYC - 1);
  assign cnt     = {rx_data, lo_q};
  assign cnt_ok  = cnt != 16'd0 && {16'd0, cnt} <= (32'd1 << ADDR_W);
  boot_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (sync),
    .en         (rx_valid && state_q == S_DATA),
    .din        (rx_data),
    .word       (word),
    .word_valid (word_valid),
    .last_byte  (last_byte),
    .csum       (csum)
  );
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    n_d     = n_q;
    widx_d  = word_valid ? widx_q + ONE : widx_q;
    done_d  = done_q;
    err_d   = err_q;
    gap_d   = (active && !rx_valid) ? gap_q + GW'(1) : '0;
    if (sync) begin
      state_d = S_CNT_LO;
      widx_d  = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (timeout) begin
      state_d = S_HALT;
      err_d   = 1'b1;
    end else if (state_q == S_RELEASE) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        S_CNT_LO: begin
          lo_d    = rx_data;
          state_d = S_CNT_HI;
        end
        S_CNT_HI: begin
          n_d     = cnt[ADDR_W:0];
          state_d = cnt_ok ? S_DATA : S_HALT;
          err_d   = !cnt_ok;
        end
        // the final word is decided on its 4th byte so a back-to-back CSUM byte is not taken as data
        S_DATA: state_d = (last_byte && widx_q + ONE == n_q) ? S_CSUM : S_DATA;
        S_CSUM: begin
          state_d = rx_data == csum ? S_RELEASE : S_HALT;
          done_d  = rx_data == csum;
          err_d   = rx_data != csum;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      n_q     <= '0;
      widx_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign mem_addr    = idle ? cpu_addr[ADDR_W+1:2] : widx_q[ADDR_W-1:0];
  assign cpu_rdata   = idle ? mem_rdata : NOP;
  assign cpu_stall   = !idle;
  assign mem_we      = word_valid;
  assign mem_wdata   = word;
  assign cpu_rst_req = state_q == S_RELEASE;
  assign load_busy   = active || state_q == S_RELEASE;
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
endmodule

// File: tb/tb_imem_boot_arbiter.sv
// tb_imem_boot_arbiter: self-checking bench with table vectors, directed frames and random frames
module tb_imem_boot_arbiter;
  localparam int TO = 100;
  logic        clk = 1'b0, rst = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_rdata, mem_rdata, mem_wdata;
  logic [7:0]  mem_addr;
  logic        mem_we, cpu_stall, cpu_rst_req, load_busy, load_done, load_err;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] mem [256];
  bit          wr_flag [256];
  int          wr_n = 0, rreq_n = 0;
  logic [7:0]  log_a [4096];
  logic [31:0] log_d [4096];
  logic [31:0] words [$];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  ma;
    logic [31:0] rd;
  } vec_t;
  vec_t tv [5];

  always #5 clk = ~clk;

  imem_boot_arbiter #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .cpu_stall(cpu_stall), .cpu_rst_req(cpu_rst_req),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  // bench-side imem: unwritten words read back as C0DE00xx
  assign mem_rdata = wr_flag[mem_addr] ? mem[mem_addr] : {24'hC0DE00, mem_addr};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      wr_flag[mem_addr] <= 1'b1;
      log_a[wr_n]       <= mem_addr;
      log_d[wr_n]       <= mem_wdata;
      wr_n              <= wr_n + 1;
    end
    if (cpu_rst_req) rreq_n <= rreq_n + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_g(input logic [7:0] b, input int g);
    idle($urandom_range(g, 0));
    send(b);
  endtask

  // frame built from the words queue: SYNC, count LE, data LE, XOR of data bytes
  task automatic send_frame(input int n, input bit bad, input int g);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    send_g(8'hA5, g);
    send_g(n[7:0], g);
    send_g(n[15:8], g);
    foreach (words[i]) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        cs ^= w[8*k +: 8];
        send_g(w[8*k +: 8], g);
      end
    end
    send_g(bad ? ~cs : cs, g);
  endtask

  task automatic chk_writes(input int base, input string nm);
    chk({nm, " write count"}, wr_n - base, words.size());
    for (int i = 0; i < words.size() && i < wr_n - base; i++) begin
      chk({nm, " write addr"}, 32'(log_a[base+i]), i);
      chk({nm, " write data"}, log_d[base+i], words[i]);
    end
  endtask

  // called at the negedge right after the CSUM byte: RELEASE for good, HALT for bad
  task automatic expect_load(input int base, input int rb, input bit bad, input string nm);
    chk({nm, " rst_req"}, 32'(cpu_rst_req), bad ? 0 : 1);
    chk({nm, " done"}, 32'(load_done), bad ? 0 : 1);
    chk({nm, " err"}, 32'(load_err), bad ? 1 : 0);
    chk({nm, " busy"}, 32'(load_busy), bad ? 0 : 1);
    chk({nm, " stall end"}, 32'(cpu_stall), 1);
    @(negedge clk);
    chk({nm, " stall after"}, 32'(cpu_stall), bad ? 1 : 0);
    chk({nm, " rst_req pulses"}, rreq_n - rb, bad ? 0 : 1);
    chk_writes(base, nm);
  endtask

  initial begin
    int base, rb, n, sel;
    bit bad;
    logic [7:0] fb [12];
    logic [7:0] cs;
    logic [31:0] w;
    fb = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h30, 8'h00, 8'h93, 8'h00, 8'hC0, 8'h01, 8'h71};
    tv[0] = '{32'h0000_0008, 8'h02, 32'hC0DE_0002};
    tv[1] = '{32'h0000_0000, 8'h00, 32'hC0DE_0000};
    tv[2] = '{32'h0000_03FC, 8'hFF, 32'hC0DE_00FF};
    tv[3] = '{32'h0000_0400, 8'h00, 32'hC0DE_0000};
    tv[4] = '{32'h0000_1237, 8'h8D, 32'hC0DE_008D};

    #2 rst = 1'b1;
    #1;
    chk("reset stall", 32'(cpu_stall), 0);
    chk("reset we", 32'(mem_we), 0);
    chk("reset rst_req", 32'(cpu_rst_req), 0);
    chk("reset busy", 32'(load_busy), 0);
    chk("reset done", 32'(load_done), 0);
    chk("reset err", 32'(load_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      cpu_addr = tv[i].addr;
      #1;
      chk("idle mem_addr", 32'(mem_addr), 32'(tv[i].ma));
      chk("idle cpu_rdata", cpu_rdata, tv[i].rd);
      chk("idle stall", 32'(cpu_stall), 0);
    end
    @(negedge clk);

    // good two-word frame, back-to-back bytes
    words = '{32'h0030_0013, 32'h01C0_0093};
    base = wr_n; rb = rreq_n;
    chk("t2 stall before sync", 32'(cpu_stall), 0);
    send(fb[0]);
    chk("t2 stall after sync", 32'(cpu_stall), 1);
    chk("t2 busy after sync", 32'(load_busy), 1);
    chk("t2 nop", cpu_rdata, 32'h0000_0013);
    for (int i = 1; i < 12; i++) send(fb[i]);
    expect_load(base, rb, 1'b0, "t2");
    cpu_addr = 32'h4;
    #1 chk("t2 fetch word1", cpu_rdata, 32'h01C0_0093);

    // same frame with a corrupted checksum, then recovery
    base = wr_n; rb = rreq_n;
    for (int i = 0; i < 11; i++) send(fb[i]);
    send(fb[11] ^ 8'hFF);
    expect_load(base, rb, 1'b1, "t3");
    idle(5);
    chk("t3 halt stall held", 32'(cpu_stall), 1);
    chk("t3 no rst_req", rreq_n - rb, 0);
    words = '{$urandom(), $urandom()};
    base = wr_n; rb = rreq_n;
    send_frame(2, 1'b0, 2);
    expect_load(base, rb, 1'b0, "t3 recover");

    // timeout after two data bytes
    base = wr_n;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(TO - 1);
    chk("t4 err before expiry", 32'(load_err), 0);
    chk("t4 busy before expiry", 32'(load_busy), 1);
    idle(1);
    chk("t4 err at expiry", 32'(load_err), 1);
    chk("t4 stall in halt", 32'(cpu_stall), 1);
    chk("t4 busy in halt", 32'(load_busy), 0);
    chk("t4 no writes", wr_n - base, 0);

    // byte arriving exactly in the expiry cycle is accepted
    words = '{$urandom()};
    base = wr_n; rb = rreq_n;
    send(8'hA5); send(8'h01); send(8'h00);
    idle(TO - 1);
    cs = 8'h00;
    w = words[0];
    for (int k = 0; k < 4; k++) begin
      cs ^= w[8*k +: 8];
      send(w[8*k +: 8]);
    end
    send(cs);
    expect_load(base, rb, 1'b0, "t4 edge gap");

    // illegal word counts
    base = wr_n;
    send(8'hA5);
    chk("t5 err cleared by sync", 32'(load_err), 0);
    send(8'h00); send(8'h00);
    chk("t5 N=0 err", 32'(load_err), 1);
    chk("t5 N=0 stall", 32'(cpu_stall), 1);
    send(8'hA5); send(8'h01); send(8'h01);
    chk("t5 N=257 err", 32'(load_err), 1);
    chk("t5 N=257 busy", 32'(load_busy), 0);
    chk("t5 no writes", wr_n - base, 0);

    // largest legal frame, N=256
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back($urandom());
    base = wr_n; rb = rreq_n;
    send_frame(256, 1'b0, 0);
    expect_load(base, rb, 1'b0, "t5 N=256");

    // async reset mid-DATA, then non-SYNC bytes in IDLE
    w = $urandom();
    base = wr_n;
    send(8'hA5); send(8'h02); send(8'h00);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
    send(8'h5A); send(8'h3C);
    chk("t6 busy mid data", 32'(load_busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6 stall on rst", 32'(cpu_stall), 0);
    chk("t6 busy on rst", 32'(load_busy), 0);
    chk("t6 we on rst", 32'(mem_we), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6 one word kept", wr_n - base, 1);
    cpu_addr = 32'h0;
    #1 chk("t6 word0 survives", cpu_rdata, w);
    @(negedge clk);
    send(8'h48);
    chk("t6 0x48 ignored", 32'(cpu_stall), 0);
    send(8'h65);
    chk("t6 0x65 ignored", 32'(cpu_stall), 0);
    chk("t6 0x65 busy", 32'(load_busy), 0);

    // random frames against the frame model
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(6, 1);
      bad = $urandom_range(3, 0) == 0;
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom());
      base = wr_n; rb = rreq_n;
      send_frame(n, bad, 3);
      expect_load(base, rb, bad, "rnd");
      if (!bad) begin
        sel = $urandom_range(n - 1, 0);
        cpu_addr = ($urandom() & 32'hFFFF_FC03) | 32'(sel << 2);
        #1 chk("rnd fetch", cpu_rdata, words[sel]);
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
